// File: rtl/mux81_sched_pkg.sv
// Shared types and constants for the 8-way round-robin MUX81 scheduler.
package mux81_sched_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} sched_state_t;
  typedef logic [N_SRC-1:0] req_vec_t;

  // Pointer reset value chosen so the first search after reset starts at index 0.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_SRC - 1);

endpackage

// File: rtl/mux81_rr_pick.sv
// Round-robin pick: lowest set req bit searching upward from last+1 with wrap.
// Purely combinational (0 cycles); no backpressure.
module mux81_rr_pick
  import mux81_sched_pkg::*;
(
  input  req_vec_t         req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  // Walk from the lowest-priority offset to the highest so the nearest match wins.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int i = N_SRC; i >= 1; i--) begin
      if (req[last + SEL_W'(i)]) winner = last + SEL_W'(i);
    end
  end

endmodule

// File: rtl/mux81_rr_sched.sv
// Round-robin owner of one MUX81: grant 1 cycle after req, at most HOLD_MAX cycles, 1 release cycle.
// Samples trail grant by 1 cycle; no backpressure. MUX81_SCHED_STATS_EN adds per-source grant counters.
module mux81_rr_sched
  import mux81_sched_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  req_vec_t         req,
  input  logic             y_in,
  output logic [SEL_W-1:0] select,
  output logic             enable_b,
  output req_vec_t         grant,
  output logic             sample_data,
  output logic [SEL_W-1:0] sample_src,
  output logic             sample_valid,
`ifdef MUX81_SCHED_STATS_EN
  input  logic [SEL_W-1:0] stat_sel,
  output logic [15:0]      stat_count,
`endif
  output logic             busy
);

  sched_state_t     state_q;
  logic [SEL_W-1:0] select_q;
  logic [SEL_W-1:0] last_q;
  logic [CNT_W-1:0] hold_cnt_q;
  req_vec_t         grant_q;
  logic             enable_b_q;
  logic             busy_q;
  logic             sample_data_q;
  logic [SEL_W-1:0] sample_src_q;
  logic             sample_valid_q;

  logic [SEL_W-1:0] pick_winner;
  logic             pick_any;
  logic             launch_d;
  logic             grant_end_d;

  mux81_rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // IDLE and RELEASE both launch a new grant straight from the picker.
  assign launch_d    = (state_q != GRANT) && pick_any;
  assign grant_end_d = !req[last_q] || (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= IDLE;
      select_q       <= '0;
      last_q         <= LAST_RST;
      hold_cnt_q     <= '0;
      grant_q        <= '0;
      enable_b_q     <= 1'b1;
      busy_q         <= 1'b0;
      sample_data_q  <= 1'b0;
      sample_src_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (state_q == GRANT) begin
        sample_data_q  <= y_in;
        sample_src_q   <= select_q;
        sample_valid_q <= 1'b1;
      end

      if (launch_d) begin
        state_q    <= GRANT;
        select_q   <= pick_winner;
        last_q     <= pick_winner;
        grant_q    <= req_vec_t'(1) << pick_winner;
        enable_b_q <= 1'b0;
        hold_cnt_q <= '0;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          GRANT: begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            if (grant_end_d) begin
              state_q    <= RELEASE;
              grant_q    <= '0;
              enable_b_q <= 1'b1;
            end
          end
          RELEASE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef MUX81_SCHED_STATS_EN
  logic [15:0] stat_q [N_SRC];

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < N_SRC; i++) stat_q[i] <= '0;
    end else if (launch_d && (stat_q[pick_winner] != 16'hFFFF)) begin
      stat_q[pick_winner] <= stat_q[pick_winner] + 16'd1;
    end
  end

  assign stat_count = stat_q[stat_sel];
`endif

  assign select       = select_q;
  assign enable_b     = enable_b_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign sample_data  = sample_data_q;
  assign sample_src   = sample_src_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_mux81_rr_sched.sv
// Directed bench for mux81_rr_sched with a behavioural MUX81 and a sample scoreboard.
module tb_mux81_rr_sched;

  logic       clock;
  logic       reset_b;
  logic [7:0] req;
  logic       y_in;
  logic [2:0] select;
  logic       enable_b;
  logic [7:0] grant;
  logic       sample_data;
  logic [2:0] sample_src;
  logic       sample_valid;
  logic       busy;

  logic [7:0] data_r;
  int         n_chk;
  int         n_err;
  logic [2:0] exp_sel;

  typedef struct packed {
    logic [2:0] src;
    logic       dat;
  } smp_t;
  smp_t sq[$];

  mux81_rr_sched #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset_b      (reset_b),
    .req          (req),
    .y_in         (y_in),
    .select       (select),
    .enable_b     (enable_b),
    .grant        (grant),
    .sample_data  (sample_data),
    .sample_src   (sample_src),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  // Behavioural MUX81: output forced low while disabled.
  assign y_in = enable_b ? 1'b0 : data_r[select];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // One clock: check outputs after the edge, retire a due sample, queue the next one.
  task automatic step(input logic [7:0] eg, input logic eb);
    smp_t s;
    @(posedge clock);
    #1;
    chk("grant", 32'(grant), 32'(eg));
    chk("enable_b", 32'(enable_b), 32'(eg == 8'h00));
    chk("busy", 32'(busy), 32'(eb));
    if (eg != 8'h00) exp_sel = onehot_idx(eg);
    chk("select", 32'(select), 32'(exp_sel));
    chk("sample_valid", 32'(sample_valid), 32'(sq.size() != 0));
    if (sample_valid === 1'b1 && sq.size() != 0) begin
      s = sq.pop_front();
      chk("sample_src", 32'(sample_src), 32'(s.src));
      chk("sample_data", 32'(sample_data), 32'(s.dat));
    end
    if (eg != 8'h00) sq.push_back('{src: exp_sel, dat: data_r[exp_sel]});
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    exp_sel = 3'd0;
    data_r  = 8'hA5;
    req     = 8'hFF;
    reset_b = 1'b0;

    // Reset held with every requester active.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_enable_b", 32'(enable_b), 32'd1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample_data", 32'(sample_data), 32'd0);
    chk("rst_sample_src", 32'(sample_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_b = 1'b1;

    // All requesting: full rotation 0..7 then back to 0.
    for (int i = 0; i < 8; i++) begin
      repeat (4) step(8'h01 << i, 1'b1);
      step(8'h00, 1'b1);
    end
    step(8'h01, 1'b1);
    req = 8'h00;
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // Sole requester wraps back to itself; req drop inside RELEASE ends it.
    req = 8'h01;
    for (int r = 0; r < 2; r++) begin
      repeat (4) step(8'h01, 1'b1);
      step(8'h00, 1'b1);
    end
    req = 8'h00;
    step(8'h00, 1'b0);

    // Early drop after two grant cycles.
    req = 8'h08;
    step(8'h08, 1'b1);
    step(8'h08, 1'b1);
    req = 8'h00;
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // Sampling through the mux with data bit set, then cleared.
    data_r = 8'h20;
    req    = 8'h20;
    repeat (4) step(8'h20, 1'b1);
    req = 8'h00;
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    data_r = 8'h00;
    req    = 8'h20;
    repeat (4) step(8'h20, 1'b1);
    req = 8'h00;
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // Asynchronous reset in the middle of a grant.
    data_r = 8'h5A;
    req    = 8'h04;
    step(8'h04, 1'b1);
    step(8'h04, 1'b1);
    #4;
    reset_b = 1'b0;
    #1;
    chk("arst_enable_b", 32'(enable_b), 32'd1);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_select", 32'(select), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sample_valid", 32'(sample_valid), 32'd0);
    sq.delete();
    exp_sel = 3'd0;
    @(posedge clock);
    #1;
    req     = 8'h14;
    reset_b = 1'b1;
    repeat (4) step(8'h04, 1'b1);
    step(8'h00, 1'b1);
    repeat (4) step(8'h10, 1'b1);
    step(8'h00, 1'b1);
    req = 8'h00;
    step(8'h00, 1'b0);
    chk("sq_drained", 32'(sq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
